yblock_cfg_loader: RTL and testbench

- Synchronous configuration front-end that sits directly upstream of a yellow-cell block.
- Accepts column-parallel configuration words over a valid/ready handshake.
- Presents each word on the block's per-column configuration-bit inputs and generates a clean confclk strobe with guaranteed setup/hold.
- Counts words so exactly one full configuration chain is shifted per session, then reports done.

---
 rtl/yblock_pkg.sv | 28 ++
 rtl/cfg_strobe_gen.sv | 58 +++++
 rtl/yblock_cfg_loader.sv | 150 +++++++++++++++
 tb/tb_yblock_cfg_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yblock_pkg.sv
// Shared definitions for the yellow-cell block family: configuration-loader
// FSM encoding, default cell depth, and the two-bit signal value constants.
package yblock_pkg;

    // Configuration bits held by each cell unless a design overrides it.
    localparam int BITSPERCELL_DEF = 3;

    // Two-bit signal values used across the block family.
    localparam logic [1:0] VEMPTY = 2'b00;
    localparam logic [1:0] V0     = 2'b01;
    localparam logic [1:0] V1     = 2'b10;

    // Loader FSM states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } cfg_state_e;

    // A session is in progress in every state except IDLE and DONE.
    function automatic logic is_busy(input cfg_state_e s);
        return (s == S_LOAD) || (s == S_SETUP) || (s == S_STROBE) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/cfg_strobe_gen.sv
// Strobe timer: after a one-cycle go (issued in SETUP) drives a registered
// confclk high for strobe_len cycles and flags the last high cycle so the
// loader can move into HOLD. abort drops confclk on the next cycle.
module cfg_strobe_gen
    import yblock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       abort,
    input  logic [3:0] strobe_len,
    output logic       confclk,
    output logic       hold_pulse
);

    logic       confclk_q, confclk_d;
    logic [3:0] cnt_q, cnt_d;

    // Last high cycle of the strobe: HOLD follows.
    assign hold_pulse = confclk_q && (cnt_q == strobe_len);
    assign confclk    = confclk_q;

    // Next strobe level and high-cycle count.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        confclk_d = confclk_q;
        cnt_d     = cnt_q;
        if (abort) begin
            confclk_d = 1'b0;
            cnt_d     = 4'd0;
        end else if (go) begin
            confclk_d = 1'b1;
            cnt_d     = 4'd1;
        end else if (confclk_q) begin
            if (cnt_q == strobe_len) begin
                confclk_d = 1'b0;
                cnt_d     = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Strobe registers; confclk comes straight from a flop so it cannot glitch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            confclk_q <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            confclk_q <= confclk_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/yblock_cfg_loader.sv
// Configuration front-end for a yellow-cell block: takes column-parallel
// words over valid/ready, presents each on cbitout, strobes confclk with one
// cycle of setup and hold, and reports done after BLOCKHEIGHT*BITSPERCELL
// words. Optional readback of the block's chain output is enabled by
// defining YBLOCK_CFG_READBACK_EN.
module yblock_cfg_loader
    import yblock_pkg::*;
#(
    parameter int BLOCKWIDTH    = 8,
    parameter int BLOCKHEIGHT   = 8,
    parameter int BITSPERCELL   = BITSPERCELL_DEF,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BLOCKWIDTH-1:0] wdata,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  busy,
    output logic                  done,
    output logic                  blk_reset,
    output logic                  confclk,
    output logic [BLOCKWIDTH-1:0] cbitout,
    input  logic [BLOCKWIDTH-1:0] cbitret
`ifdef YBLOCK_CFG_READBACK_EN
    ,
    output logic [BLOCKWIDTH-1:0] rdata,
    output logic                  rvalid
`endif
);

    localparam int              TOTAL      = BLOCKHEIGHT * BITSPERCELL;
    localparam int              CW         = $clog2(TOTAL + 1);
    localparam logic [CW-1:0]   TOTAL_C    = CW'(TOTAL);
    localparam logic [3:0]      STROBE_LEN = 4'(STROBE_CYCLES);

    cfg_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BLOCKWIDTH-1:0] cbit_q, cbit_d;
    logic                  blk_reset_q, blk_reset_d;
    logic                  go;
    logic                  hold_pulse;

    cfg_strobe_gen u_strobe_gen (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .abort      (start),
        .strobe_len (STROBE_LEN),
        .confclk    (confclk),
        .hold_pulse (hold_pulse)
    );

    assign busy      = is_busy(state_q);
    assign done      = (state_q == S_DONE);
    assign blk_reset = blk_reset_q;
    assign cbitout   = cbit_q;

    // Session sequencing; a start in any state restarts from LOAD with the
    // word counter cleared, discarding whatever partial chain was shifted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cbit_d  = cbit_q;
        wready  = 1'b0;
        go      = 1'b0;
        case (state_q)
            S_LOAD: begin
                // A restart takes priority, so no word is taken alongside it.
                wready = !start;
                if (wvalid && !start) begin
                    cbit_d  = wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                go      = !start;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (hold_pulse) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_d == TOTAL_C) ? S_DONE : S_LOAD;
            end
            S_IDLE, S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
        end
        blk_reset_d = is_busy(state_d);
    end

    // State, counter, presented word and block reset registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            // NOTE: the cbitout data register is reset as well, because it
            // drives the block directly and must not present X after reset.
            cbit_q      <= '0;
            blk_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cbit_q      <= cbit_d;
            blk_reset_q <= blk_reset_d;
        end
    end

`ifdef YBLOCK_CFG_READBACK_EN
    logic [BLOCKWIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

    // Capture the bit shifted out of each column chain during HOLD.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if ((state_q == S_HOLD) && !start) begin
            rdata_d  = cbitret;
            rvalid_d = 1'b1;
        end
    end

    // Readback registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
`else
    logic unused_cbitret;
    assign unused_cbitret = ^cbitret;
`endif

endmodule

// File: tb/tb_yblock_cfg_loader.sv
// Bench for yblock_cfg_loader: instance 0 uses STROBE_CYCLES=1, instance 1
// uses STROBE_CYCLES=3. A cycles-since-accept model predicts all outputs and
// is compared every cycle; directed sessions add literal timing checks.
module tb_yblock_cfg_loader;

    localparam int W      = 8;
    localparam int TOTAL  = 24;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_TIME = 2;
    localparam int P_DONE = 3;

    int strobe_len [2] = '{1, 3};

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start  [2];
    logic         wvalid [2];
    logic [W-1:0] wdata  [2];
    logic         wready [2];
    logic         busy   [2];
    logic         done   [2];
    logic         blk_reset [2];
    logic         confclk [2];
    logic [W-1:0] cbitout [2];
    wire  [W-1:0] cbitret [2];
    logic [W-1:0] ret0 = '0;
`ifdef YBLOCK_CFG_READBACK_EN
    logic [W-1:0] rdata  [2];
    logic         rvalid [2];
    logic [W-1:0] rb_q [$];
    bit           rb_en = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    assign cbitret[0] = ret0;
    assign cbitret[1] = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        yblock_cfg_loader #(
            .BLOCKWIDTH    (W),
            .BLOCKHEIGHT   (8),
            .BITSPERCELL   (3),
            .STROBE_CYCLES ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start[g]),
            .wdata     (wdata[g]),
            .wvalid    (wvalid[g]),
            .wready    (wready[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .blk_reset (blk_reset[g]),
            .confclk   (confclk[g]),
            .cbitout   (cbitout[g]),
            .cbitret   (cbitret[g])
`ifdef YBLOCK_CFG_READBACK_EN
            ,
            .rdata     (rdata[g]),
            .rvalid    (rvalid[g])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Block model for instance 0: a 24-deep chain per column; each rising
    // confclk shifts cbitout in and presents the word shifted out.
    logic [W-1:0] chain [$];
    initial for (int i = 0; i < TOTAL; i++) chain.push_back('0);
    always @(posedge confclk[0]) begin
        ret0 = chain.pop_front();
        chain.push_back(cbitout[0]);
    end

    // Behavioural model: phase plus cycles elapsed since the word was accepted.
    int           m_phase [2] = '{P_IDLE, P_IDLE};
    int           m_since [2] = '{0, 0};
    int           m_cnt   [2] = '{0, 0};
    int           m_nacc  [2] = '{0, 0};
    logic [W-1:0] m_cbit  [2];
    logic [W-1:0] m_rd    [2];
    bit           m_acc   [2];
    bit           m_rv    [2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_acc[u] = 1'b0;
            m_rv[u]  = 1'b0;
            if (reset) begin
                m_phase[u] = P_IDLE;
                m_cnt[u]   = 0;
                m_since[u] = 0;
                m_cbit[u]  = '0;
                m_rd[u]    = '0;
            end else if (start[u]) begin
                m_phase[u] = P_LOAD;
                m_cnt[u]   = 0;
                m_since[u] = 0;
            end else if (m_phase[u] == P_LOAD && wvalid[u]) begin
                m_cbit[u]  = wdata[u];
                m_phase[u] = P_TIME;
                m_since[u] = 1;
                m_acc[u]   = 1'b1;
                m_nacc[u]++;
            end else if (m_phase[u] == P_TIME) begin
                if (m_since[u] == strobe_len[u] + 2) begin
                    m_rv[u] = 1'b1;
                    m_rd[u] = cbitret[u];
                    m_cnt[u]++;
                    m_phase[u] = (m_cnt[u] == TOTAL) ? P_DONE : P_LOAD;
                end else begin
                    m_since[u]++;
                end
            end
        end
    end

    // Compare process: every output against the model on each falling edge,
    // plus confclk pulse counting and width checks.
    int np [2] = '{0, 0};
    int pw [2] = '{0, 0};
    bit cf_prev [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                check($sformatf("wready[%0d]", u), 32'(wready[u]), 32'(m_phase[u] == P_LOAD));
                check($sformatf("busy[%0d]", u), 32'(busy[u]),
                      32'(m_phase[u] == P_LOAD || m_phase[u] == P_TIME));
                check($sformatf("blk_reset[%0d]", u), 32'(blk_reset[u]),
                      32'(m_phase[u] == P_LOAD || m_phase[u] == P_TIME));
                check($sformatf("done[%0d]", u), 32'(done[u]), 32'(m_phase[u] == P_DONE));
                check($sformatf("confclk[%0d]", u), 32'(confclk[u]),
                      32'(m_phase[u] == P_TIME && m_since[u] >= 2 && m_since[u] <= strobe_len[u] + 1));
                check($sformatf("cbitout[%0d]", u), 32'(cbitout[u]), 32'(m_cbit[u]));
`ifdef YBLOCK_CFG_READBACK_EN
                check($sformatf("rvalid[%0d]", u), 32'(rvalid[u]), 32'(m_rv[u]));
                check($sformatf("rdata[%0d]", u), 32'(rdata[u]), 32'(m_rd[u]));
                if (u == 0 && rb_en && rvalid[0] === 1'b1) rb_q.push_back(rdata[0]);
`endif
                if (confclk[u] === 1'b1) begin
                    pw[u]++;
                end else if (cf_prev[u]) begin
                    // Only pulses that ended normally (model in HOLD) count.
                    if (m_phase[u] == P_TIME) begin
                        check($sformatf("pulse_width[%0d]", u), 32'(pw[u]), 32'(strobe_len[u]));
                        np[u]++;
                    end
                    pw[u] = 0;
                end
                cf_prev[u] = (confclk[u] === 1'b1);
            end
        end
    end

    // One session on instance u. Inputs change 1 time unit after each edge.
    // abort_word >= 0 restarts the session in the 2nd strobe cycle of word
    // abort_word+1; exp_done > 0 pins the cycle count from start to done.
    task automatic run_session(input int u, input logic [7:0] base, input bit bp,
                               input int abort_word, input logic [7:0] base2,
                               input int exp_done, input bit chk_spacing);
        int  cyc, idx, done_cyc, last_acc, np0, acc0, exp_pulses, exp_acc;
        bit  aborted;
        logic [7:0] cur;
        cur = base;
        start[u]  = 1'b1;
        wvalid[u] = 1'b0;
        @(posedge clk); #1;
        start[u]  = 1'b0;
        cyc = 0; idx = 0; done_cyc = -1; last_acc = -1; aborted = 1'b0;
        np0 = np[u]; acc0 = m_nacc[u];
        wdata[u]  = cur;
        wvalid[u] = 1'b1;
        while (cyc < 600 && !(done_cyc >= 0 && cyc >= done_cyc + 8)) begin
            @(posedge clk); #1;
            cyc++;
            if (start[u]) begin
                start[u] = 1'b0;
                check("abort_confclk", 32'(confclk[u]), 32'd0);
                check("abort_count", 32'(m_cnt[u]), 32'd0);
            end
            if (m_acc[u]) begin
                idx++;
                if (chk_spacing && last_acc >= 0)
                    check("accept_spacing", 32'(cyc - last_acc), 32'(3 + strobe_len[u]));
                last_acc = cyc;
            end
            if (done[u] === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (abort_word >= 0 && !aborted && m_phase[u] == P_TIME &&
                m_cnt[u] == abort_word && m_since[u] == 3) begin
                start[u] = 1'b1;
                aborted  = 1'b1;
                idx      = 0;
                cyc      = -1;
                last_acc = -1;
                cur      = base2;
            end
            wdata[u] = (idx < TOTAL) ? 8'(cur + idx) : 8'hEE;
            // Irregular valid pattern so LOAD waits vary from word to word.
            wvalid[u] = bp ? (((cyc * 5) % 7) < 3) : 1'b1;
        end
        exp_pulses = TOTAL + ((abort_word >= 0) ? abort_word : 0);
        exp_acc    = TOTAL + ((abort_word >= 0) ? abort_word + 1 : 0);
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
        else if (exp_done > 0) check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("pulse_count", 32'(np[u] - np0), 32'(exp_pulses));
        check("words_accepted", 32'(m_nacc[u] - acc0), 32'(exp_acc));
        check("final_cbitout", 32'(cbitout[u]), 32'(8'(cur + TOTAL - 1)));
        wvalid[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; wvalid[u] = 1'b0; wdata[u] = '0;
        end
        // Reset, including a start pulse that reset must override.
        @(posedge clk); #1;
        chk_en   = 1'b1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("idle_wready", 32'(wready[u]), 32'd0);
            check("idle_confclk", 32'(confclk[u]), 32'd0);
            check("idle_done", 32'(done[u]), 32'd0);
            check("idle_cbitout", 32'(cbitout[u]), 32'h00);
        end

        // Full session, words 01..18, one per 4 cycles; done 96 cycles after start.
        run_session(0, 8'h01, 1'b0, -1, 8'h00, 96, 1'b1);
        // Backpressure, then extra words offered in DONE.
        run_session(0, 8'h21, 1'b1, -1, 8'h00, 0, 1'b0);
        // STROBE_CYCLES=3: 6-cycle spacing, done after 144 cycles.
        run_session(1, 8'h51, 1'b0, -1, 8'h00, 144, 1'b1);
        // Abort during the 2nd strobe cycle of the 5th word, then a full session.
        run_session(1, 8'h71, 1'b0, 4, 8'hA1, 144, 1'b0);

`ifdef YBLOCK_CFG_READBACK_EN
        begin
            int n0;
            run_session(0, 8'h81, 1'b0, -1, 8'h00, 96, 1'b0);
            n0    = rb_q.size();
            rb_en = 1'b1;
            run_session(0, 8'hC1, 1'b0, -1, 8'h00, 96, 1'b0);
            rb_en = 1'b0;
            check("readback_count", 32'(rb_q.size() - n0), 32'(TOTAL));
            for (int k = 0; k < TOTAL; k++) begin
                if (n0 + k < rb_q.size())
                    check($sformatf("readback[%0d]", k), 32'(rb_q[n0 + k]), 32'(8'(8'h81 + k)));
            end
        end
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
